// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: state encoding and frame-length helper.
package fft_seq_pkg;

  localparam int unsigned TOTAL_STAGE_DEF = 10;
  localparam int unsigned N = 1 << TOTAL_STAGE_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic int unsigned frame_len(input int unsigned stages);
    return 32'd1 << stages;
  endfunction

endpackage

// File: rtl/fft_frame_seq_outst.sv
// In-flight sample counter: +1 per issued sample, -1 per pipeline return, flags returns with nothing in flight.
module fft_outst_cnt #(
  parameter int W = 12
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         iinc,
  input  logic         idec,
  output logic [W-1:0] ocnt,
  output logic         ounderflow
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d      = cnt_q;
    ounderflow = 1'b0;
    if (iinc && !idec) begin
      cnt_d = cnt_q + W'(1);
    end else if (!iinc && idec) begin
      // A return with nothing outstanding is reported, never wrapped around.
      if (cnt_q == '0) ounderflow = 1'b1;
      else             cnt_d      = cnt_q - W'(1);
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign ocnt = cnt_q;

endmodule

// File: rtl/fft_frame_seq.sv
// Frame sequencer feeding the pipelined FFT/IFFT: frames the input stream, latches the mode,
// and reports completion once every issued sample has come back out of the pipeline.
// Handshake: a sample transfers on a cycle where ivalid and oready are both high; the source
// holds idata while ivalid is high and oready is low.
module fft_frame_seq
  import fft_seq_pkg::*;
#(
  parameter int TOTAL_STAGE_P = 10,
  parameter int MULT_WIDTH_P  = 18,
  parameter int FRAMES_W      = 8,
  parameter int OUTST_W       = 12
) (
  input  logic                      iclk,
  input  logic                      irst,
  input  logic                      istart,
  input  logic                      iinv,
  input  logic [FRAMES_W-1:0]       inum_frames,
  input  logic                      istop,
  input  logic                      ivalid,
  input  logic [2*MULT_WIDTH_P-1:0] idata,
  output logic                      oready,
  output logic                      open,
  output logic [TOTAL_STAGE_P-1:0]  oaddr,
  output logic [2*MULT_WIDTH_P-1:0] odata,
  output logic                      oinv,
  input  logic                      ipipe_oen,
  output logic                      obusy,
  output logic                      odone,
  output logic [FRAMES_W-1:0]       oframe_cnt,
  output logic                      oerr
);

  localparam int unsigned FRAME_LEN = frame_len(TOTAL_STAGE_P);
  localparam logic [TOTAL_STAGE_P-1:0] LAST_ADDR = TOTAL_STAGE_P'(FRAME_LEN - 1);

  seq_state_e                 state_q, state_d;
  logic [TOTAL_STAGE_P-1:0]   addr_q, addr_d;
  logic [TOTAL_STAGE_P-1:0]   oaddr_q, oaddr_d;
  logic [2*MULT_WIDTH_P-1:0]  odata_q, odata_d;
  logic                       en_q, en_d;
  logic [FRAMES_W-1:0]        frame_q, frame_d;
  logic [FRAMES_W-1:0]        target_q, target_d;
  logic                       inv_q, inv_d;
  logic                       stop_pend_q, stop_pend_d;
  logic                       err_q, err_d;

  logic                       ready;
  logic                       accept;
  logic                       wrap;
  logic                       at_frame_start;
  logic [FRAMES_W-1:0]        frame_next;
  logic [OUTST_W-1:0]         outst_cnt;
  logic                       underflow;

  fft_outst_cnt #(.W(OUTST_W)) u_outst (
    .iclk       (iclk),
    .irst       (irst),
    .iinc       (accept),
    .idec       (ipipe_oen),
    .ocnt       (outst_cnt),
    .ounderflow (underflow)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    oaddr_d     = oaddr_q;
    odata_d     = odata_q;
    en_d        = 1'b0;
    frame_d     = frame_q;
    target_d    = target_q;
    inv_d       = inv_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q | underflow;

    at_frame_start = (addr_q == '0);
    // A stop seen at a frame boundary must not let a new frame begin, even in that same cycle.
    ready      = (state_q == ST_RUN) && !(at_frame_start && (stop_pend_q || istop));
    accept     = ready && ivalid;
    wrap       = accept && (addr_q == LAST_ADDR);
    frame_next = frame_q + FRAMES_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (istart) begin
          inv_d       = iinv;
          target_d    = inum_frames;
          frame_d     = '0;
          err_d       = 1'b0;
          addr_d      = '0;
          stop_pend_d = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          en_d    = 1'b1;
          oaddr_d = addr_q;
          odata_d = idata;
          addr_d  = addr_q + TOTAL_STAGE_P'(1);
        end
        if (istop && !at_frame_start) stop_pend_d = 1'b1;
        if (wrap) begin
          frame_d = frame_next;
          if (((target_q != '0) && (frame_next == target_q)) || stop_pend_q || istop) begin
            stop_pend_d = 1'b0;
            state_d     = ST_FLUSH;
          end
        end else if (at_frame_start && (stop_pend_q || istop)) begin
          stop_pend_d = 1'b0;
          state_d     = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (outst_cnt == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      oaddr_q     <= '0;
      odata_q     <= '0;
      en_q        <= 1'b0;
      frame_q     <= '0;
      target_q    <= '0;
      inv_q       <= 1'b0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      oaddr_q     <= oaddr_d;
      odata_q     <= odata_d;
      en_q        <= en_d;
      frame_q     <= frame_d;
      target_q    <= target_d;
      inv_q       <= inv_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
    end
  end

  assign oready     = ready;
  assign open       = en_q;
  assign oaddr      = oaddr_q;
  assign odata      = odata_q;
  assign oinv       = inv_q;
  assign obusy      = (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign odone      = (state_q == ST_DONE);
  assign oframe_cnt = frame_q;
  assign oerr       = err_q;

endmodule
